// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial shift-chain blocks.
// Used by the transmitter and by the receiver benches.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word hold buffer.
// Gapless back-to-back words; first/last markers on every word.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shifted;
  logic             acc;

  logic out_n, valid_n, first_n, last_n, busy_n;

  // Ready comes straight from the hold flag, never from in_valid.
  assign in_ready = ~hold_full;
  assign acc      = in_valid & ~hold_full;

  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                             : {1'b0, sreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      cnt       <= cnt_n;
      ser_out   <= out_n;
      ser_valid <= valid_n;
      ser_first <= first_n;
      ser_last  <= last_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    cnt_n       = cnt;
    unique case (state)
      IDLE: begin
        if (acc) begin
          sreg_n  = in_data;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (hold_full) begin
            sreg_n      = hold;
            hold_full_n = 1'b0;
          end else if (acc) begin
            sreg_n = in_data;
          end else begin
            state_n = IDLE;
          end
        end else begin
          sreg_n = shifted;
          cnt_n  = cnt + 1'b1;
          if (acc) begin
            hold_n      = in_data;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from next-state values and then registered.
  always_comb begin
    valid_n = (state_n == SHIFT);
    out_n   = valid_n &
              (MSB_FIRST ? sreg_n[WIDTH-1] : sreg_n[0]);
    first_n = valid_n && (cnt_n == '0);
    last_n  = valid_n && (cnt_n == LAST);
    busy_n  = valid_n | hold_full_n;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer, MSB-first and LSB-first.
// Expected bit streams are hand-written constants.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] a_data;
  logic       a_valid, a_ready;
  logic       a_out, a_sv, a_first, a_last, a_busy;

  logic [7:0] b_data;
  logic       b_valid, b_ready;
  logic       b_out, b_sv, b_first, b_last, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .ser_out(a_out), .ser_valid(a_sv),
    .ser_first(a_first), .ser_last(a_last), .busy(a_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .ser_out(b_out), .ser_valid(b_sv),
    .ser_first(b_first), .ser_last(b_last), .busy(b_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word on the MSB-first unit, then check all 8 bits.
  task automatic send_word(input string tag,
                           input logic [7:0] w,
                           input logic [7:0] bits);
    int nf, nl;
    nf = 0;
    nl = 0;
    a_valid = 1'b1;
    a_data  = w;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, " valid"}, a_sv, 1'b1);
      chk({tag, " bit"}, a_out, bits[7-i]);
      chk({tag, " first"}, a_first, i == 0);
      chk({tag, " last"}, a_last, i == 7);
      nf += int'(a_first);
      nl += int'(a_last);
      tick();
    end
    chk({tag, " end valid"}, a_sv, 1'b0);
    chk({tag, " nfirst"}, nf, 1);
    chk({tag, " nlast"}, nl, 1);
  endtask

  initial begin
    logic [7:0] w3 [3];
    logic [23:0] s3;
    logic [15:0] s2;
    logic [7:0] lsb_bits;
    int idx;
    logic acc;

    rst     = 1'b1;
    a_valid = 1'b0;
    a_data  = 8'h00;
    b_valid = 1'b0;
    b_data  = 8'h00;
    tick();
    tick();
    chk("rst ser_valid", a_sv, 1'b0);
    chk("rst ser_out", a_out, 1'b0);
    chk("rst first", a_first, 1'b0);
    chk("rst last", a_last, 1'b0);
    chk("rst busy", a_busy, 1'b0);
    rst = 1'b0;
    tick();
    chk("post-rst ready", a_ready, 1'b1);
    chk("post-rst idle", a_sv, 1'b0);

    // 1: single word A5, MSB first
    send_word("t1", 8'hA5, 8'b1010_0101);

    // 2: A5 then 3C back to back
    s2 = 16'b1010_0101_0011_1100;
    a_valid = 1'b1;
    a_data  = 8'hA5;
    tick();
    a_data = 8'h3C;
    for (int c = 1; c <= 16; c++) begin
      chk("t2 valid", a_sv, 1'b1);
      chk("t2 bit", a_out, s2[16-c]);
      chk("t2 first", a_first, (c == 1) || (c == 9));
      chk("t2 last", a_last, (c == 8) || (c == 16));
      chk("t2 ready", a_ready, !(c >= 2 && c <= 8));
      chk("t2 busy", a_busy, 1'b1);
      if (c == 8) a_valid = 1'b0;
      tick();
    end
    chk("t2 end valid", a_sv, 1'b0);
    chk("t2 end busy", a_busy, 1'b0);

    // 3: three words offered continuously
    w3[0] = 8'h11;
    w3[1] = 8'h22;
    w3[2] = 8'h33;
    s3 = 24'h112233;
    idx = 0;
    a_valid = 1'b1;
    a_data  = w3[0];
    for (int c = 1; c <= 24; c++) begin
      acc = a_valid && a_ready;
      tick();
      if (acc) idx++;
      a_valid = (idx < 3);
      a_data  = w3[(idx < 3) ? idx : 0];
      chk("t3 valid", a_sv, 1'b1);
      chk("t3 bit", a_out, s3[24-c]);
      chk("t3 first", a_first, (c % 8) == 1);
      chk("t3 last", a_last, (c % 8) == 0);
    end
    tick();
    chk("t3 accepted", idx, 3);
    chk("t3 end valid", a_sv, 1'b0);
    chk("t3 end busy", a_busy, 1'b0);

    // 4: LSB first, word 01
    lsb_bits = 8'h01;
    b_valid = 1'b1;
    b_data  = lsb_bits;
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4 valid", b_sv, 1'b1);
      chk("t4 bit", b_out, i == 0);
      chk("t4 first", b_first, i == 0);
      chk("t4 last", b_last, i == 7);
      tick();
    end
    chk("t4 end valid", b_sv, 1'b0);

    // 5: reset mid-word with the hold buffer full
    a_valid = 1'b1;
    a_data  = 8'hFF;
    tick();
    a_data = 8'h0F;
    tick();
    a_valid = 1'b0;
    chk("t5 hold full", a_ready, 1'b0);
    tick();
    tick();
    chk("t5 c4 valid", a_sv, 1'b1);
    chk("t5 c4 bit", a_out, 1'b1);
    rst     = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'h55;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5 rst valid", a_sv, 1'b0);
      chk("t5 rst last", a_last, 1'b0);
      chk("t5 rst busy", a_busy, 1'b0);
      chk("t5 rst ready", a_ready, 1'b1);
    end
    a_valid = 1'b0;
    rst     = 1'b0;
    tick();
    chk("t5 no accept", a_sv, 1'b0);
    chk("t5 no busy", a_busy, 1'b0);
    send_word("t5 81", 8'h81, 8'b1000_0001);

    // 6: idle gap between words
    send_word("t6 80", 8'h80, 8'b1000_0000);
    for (int i = 0; i < 4; i++) begin
      chk("t6 gap valid", a_sv, 1'b0);
      chk("t6 gap busy", a_busy, 1'b0);
      tick();
    end
    chk("t6 gap last", a_sv, 1'b0);
    send_word("t6 01", 8'h01, 8'b0000_0001);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It is the driving end for the team's serial shift-chain receivers. Words are accepted on a valid/ready handshake and shifted out one bit per clock, with first/last bit markers. A one-entry hold buffer sustains gapless back-to-back words.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 transmitted first.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
in_data  in  WIDTH  parallel word to transmit.
in_valid  in  1  in_data is valid.
in_ready  out  1  block can accept a word this cycle.
ser_out  out  1  serial data bit.
ser_valid  out  1  ser_out carries a word bit this cycle.
ser_first  out  1  current bit is the first bit of a word.
ser_last  out  1  current bit is the last bit of a word.
busy  out  1  shift in progress or hold buffer occupied.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0.
  - Hold buffer empty, bit counter 0, state IDLE.
  - in_ready=1 in the first cycle after reset deasserts.
- Handshake: a word is accepted at a posedge where in_valid && in_ready. in_ready = NOT hold_full; it is derived from a register only, with no combinational path from in_valid. in_data is sampled only at acceptance.
- States: IDLE and SHIFT.
- IDLE:
  - ser_valid=0, ser_out=0.
  - On acceptance, load the word directly into the shift register and move to SHIFT.
  - The first bit appears on ser_out in the cycle after the accepting edge (latency 1), with ser_first=1.
- SHIFT:
  - One bit per cycle. The bit counter runs 0..WIDTH-1. ser_first=1 when the counter is 0; ser_last=1 when it is WIDTH-1.
  - Acceptance while in SHIFT with the hold buffer empty writes the word into the hold buffer.
- Last-bit edge (counter = WIDTH-1), in priority order:
  - (a) Hold buffer full: move the hold word into the shift register, clear the hold buffer, counter to 0, stay in SHIFT.
  - (b) Hold buffer empty and an acceptance on the same edge: load in_data directly into the shift register, stay in SHIFT.
  - (c) Otherwise: go to IDLE; ser_valid=0 next cycle.
  - In all cases the stream stays gapless: ser_last of one word is followed immediately by ser_first of the next.
- Bit order:
  - MSB_FIRST=1 shifts left and drives bit WIDTH-1.
  - MSB_FIRST=0 shifts right and drives bit 0.
  - All outputs are registered.
- Simultaneous events: an acceptance on the edge where the hold buffer drains is legal. in_ready is 0 in that cycle anyway, so case (a) and a new acceptance never coincide.
- busy = (state == SHIFT) OR hold_full.
- Reset mid-word: rst wins over everything. The in-flight word and the hold buffer are discarded. Outputs return to reset values at the next edge, and no partial ser_last is emitted.
- in_valid asserted during rst is ignored; no acceptance occurs.

Decomposition:
- Shared package serial_pkg:
  - state enum {IDLE, SHIFT}.
  - DEFAULT_WIDTH = 8.
  - Counter-width function clog2(WIDTH).
- No sub-module. The hold buffer and shift register are simple enough to keep inline.
- Receiver benches reuse serial_pkg.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: accept 0xA5 at edge 0 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8; ser_first at cycle 1, ser_last at cycle 8; ser_valid=0 at cycle 9.
2. Back-to-back 0xA5 then 0x3C, in_valid held high -> 16 contiguous ser_valid cycles; second word bits 0,0,1,1,1,1,0,0; in_ready low from cycle 2 until the hold buffer drains at cycle 9.
3. Three words offered continuously -> third accepted only when in_ready returns to 1; 24 contiguous bits; no word lost or duplicated.
4. MSB_FIRST=0, word 0x01 -> ser_out 1 on cycle 1, then 0 for cycles 2..8.
5. rst asserted at cycle 4 of word 0xFF with the hold buffer full -> next cycle ser_valid=0, busy=0, in_ready=1, no ser_last; a new word 0x81 afterwards serializes correctly.
6. Idle gap: word 0x80, five idle cycles, then word 0x01 -> ser_valid low during the gap; each word carries exactly one ser_first and one ser_last.
